booth_mul_seq: RTL and testbench

- Multi-cycle signed multiplier sequencer (radix-2 Booth) for the CPU's MUL instruction.
- Owns no adder. Each cycle it drives the shared WIDTH-bit carry-lookahead adder, built from the 4-bit lookahead slices.
- Sequences WIDTH add/subtract/shift iterations and returns a 2*WIDTH-bit product as HI/LO.
- Control unit issues start and waits on done.

---
 rtl/booth_mul_seq.sv | 107 ++++++++++
 tb/tb_booth_mul_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier. Each RUN cycle drives the shared
// external adder once and shifts {A,Q,q_1} right by one.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             q1_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             run;
    logic             sel_add;
    logic             sel_sub;
    logic             sign_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;

    assign run     = (state_reg == ST_RUN);
    assign sel_add = run & ~q_reg[0] &  q1_reg;
    assign sel_sub = run &  q_reg[0] & ~q1_reg;

    // Subtraction is A + ~M + 1, so operand B is M, ~M or zero per bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add_b
            assign add_b[gi] = (sel_add & m_reg[gi]) | (sel_sub & ~m_reg[gi]);
        end
    endgenerate

    assign add_a   = run ? a_reg : '0;
    assign add_cin = sel_sub;

    // Sign of the (WIDTH+1)-bit sum keeps M = -2^(WIDTH-1) exact.
    assign sign_next = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
    assign a_next    = {sign_next, add_sum[WIDTH-1:1]};
    assign q_next    = {add_sum[0], q_reg[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            q1_reg    <= 1'b0;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        m_reg     <= multiplicand;
                        q_reg     <= multiplier;
                        a_reg     <= '0;
                        q1_reg    <= 1'b0;
                        count_reg <= CW'(WIDTH);
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_next;
                    q_reg     <= q_next;
                    q1_reg    <= q_reg[0];
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        hi_reg    <= a_next;
                        lo_reg    <= q_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign product_hi = hi_reg;
    assign product_lo = lo_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomised and directed bench for booth_mul_seq against an arithmetic model
// of the Booth recoding, with a behavioural adder closing the loop.
module tb_booth_mul_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    always #5 clock = ~clock;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'({{(64-W){v[W-1]}}, v});
    endfunction

    // Booth digit j of multiplier q: q[j-1] - q[j], with q[-1] = 0.
    function automatic int digit(input logic [W-1:0] q, input int j);
        int lo;
        lo = (j == 0) ? 0 : int'(q[j-1]);
        return lo - int'(q[j]);
    endfunction

    // Accumulator before iteration i: (M * sum_{j<i} d_j*2^j) >>> i.
    function automatic logic [W-1:0] booth_a(input logic [W-1:0] m, input logic [W-1:0] q, input int i);
        longint s;
        longint p;
        s = 0;
        for (int j = 0; j < i; j++)
            s = s + longint'(digit(q, j)) * (longint'(1) << j);
        p = sx(m) * s;
        p = p >>> i;
        return p[W-1:0];
    endfunction

    // Transaction model: phase 0 idle, 1..W iteration phase-1 in progress, W+1 done.
    int           m_phase = 0;
    logic [W-1:0] m_m = '0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clock) begin
        longint p;
        if (clear) begin
            m_phase = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_m = multiplicand;
                m_q = multiplier;
                m_phase = 1;
            end
        end else if (m_phase == W) begin
            p = sx(m_m) * sx(m_q);
            m_hi = p[63:32];
            m_lo = p[31:0];
            m_phase = W + 1;
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    always @(negedge clock) begin
        int d;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic ec;
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, m_phase != 0});
            chk("done", {63'd0, done}, {63'd0, m_phase == W + 1});
            chk("product_hi", {32'd0, product_hi}, {32'd0, m_hi});
            chk("product_lo", {32'd0, product_lo}, {32'd0, m_lo});
            ea = '0;
            eb = '0;
            ec = 1'b0;
            if (m_phase >= 1 && m_phase <= W) begin
                d  = digit(m_q, m_phase - 1);
                ea = booth_a(m_m, m_q, m_phase - 1);
                eb = (d == 1) ? m_m : (d == -1) ? ~m_m : '0;
                ec = (d == -1);
            end
            chk("add_a", {32'd0, add_a}, {32'd0, ea});
            chk("add_b", {32'd0, add_b}, {32'd0, eb});
            chk("add_cin", {63'd0, add_cin}, {63'd0, ec});
        end
    end

    // Called at #1 after an edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input bit noise,
                          input bit lit, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        bit seen;
        chk("idle_before_start", {63'd0, busy}, 64'd0);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        n = 0;
        seen = 0;
        while (n < 100 && !seen) begin
            @(posedge clock); #1;
            n++;
            if (done) seen = 1;
            else if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                multiplicand = $urandom;
                multiplier = $urandom;
            end
        end
        start = 1'b0;
        chk("done_latency", 64'(n), 64'(W));
        if (lit) begin
            chk("lit_hi", {32'd0, product_hi}, {32'd0, eh});
            chk("lit_lo", {32'd0, product_lo}, {32'd0, el});
            chk("model_pin_hi", {32'd0, m_hi}, {32'd0, eh});
            chk("model_pin_lo", {32'd0, m_lo}, {32'd0, el});
        end
        $display("op m=0x%08h q=0x%08h -> hi=0x%08h lo=0x%08h cycles=%0d", m, q, product_hi, product_lo, n);
        @(posedge clock); #1;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        chk_en = 1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, product_hi}, 64'd0);
        chk("reset_lo", {32'd0, product_lo}, 64'd0);

        run_op(32'd3, 32'd5, 0, 1, 32'h0000_0000, 32'h0000_000F);
        run_op(-32'sd7, 32'd6, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op(32'd6, -32'sd7, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op(32'h8000_0000, 32'h8000_0000, 0, 1, 32'h4000_0000, 32'h0000_0000);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 32'h8000_0000);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op(32'd0, 32'd0, 0, 1, 32'h0, 32'h0);

        // Start held high: one completion per accepted start, no queueing.
        dones = 0;
        start = 1'b1;
        multiplicand = 32'd2;
        multiplier = 32'd3;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        start = 1'b0;
        repeat (45) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        chk("held_start_dones", 64'(dones), 64'd2);
        chk("held_start_lo", {32'd0, product_lo}, 64'd6);
        $display("held start: dones=%0d lo=0x%08h", dones, product_lo);

        // Reset in the middle of RUN discards the operation and clears results.
        start = 1'b1;
        multiplicand = 32'd5;
        multiplier = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, product_hi}, 64'd0);
        chk("midrst_lo", {32'd0, product_lo}, 64'd0);
        $display("mid-run clear: busy=%0b hi=0x%08h lo=0x%08h", busy, product_hi, product_lo);
        run_op(32'd4, 32'd4, 0, 1, 32'h0, 32'd16);

        // Clear and start together: clear wins.
        clear = 1'b1;
        start = 1'b1;
        multiplicand = 32'd9;
        multiplier = 32'd9;
        @(posedge clock); #1;
        clear = 1'b0;
        start = 1'b0;
        chk("clear_vs_start_busy", {63'd0, busy}, 64'd0);
        @(posedge clock); #1;
        chk("clear_vs_start_busy2", {63'd0, busy}, 64'd0);
        $display("clear+start: busy=%0b", busy);

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] rm;
            logic [W-1:0] rq;
            rm = pick();
            rq = pick();
            run_op(rm, rq, k[0], 0, '0, '0);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
        end

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
